// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction SRAM arbiter, its two requesters and the SRAM.
// The slave view belongs to the arbiter; the master view belongs to everything around it.
interface imem_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   // Fetch port: read-only
   logic                  f_req_valid;
   logic                  f_req_ready;
   logic [ADDR_WIDTH-1:0] f_addr;
   logic                  f_resp_valid;
   logic [DATA_WIDTH-1:0] f_resp_data;

   // Loader / debug port: read and write
   logic                  l_req_valid;
   logic                  l_req_ready;
   logic                  l_req_write;
   logic [ADDR_WIDTH-1:0] l_addr;
   logic [DATA_WIDTH-1:0] l_wdata;
   logic                  l_resp_valid;
   logic [DATA_WIDTH-1:0] l_resp_data;

   // Single-port SRAM
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_i_write;
   logic [DATA_WIDTH-1:0] mem_i_data;
   logic [DATA_WIDTH-1:0] mem_readData;

   modport slave (
      input  f_req_valid, f_addr,
      output f_req_ready, f_resp_valid, f_resp_data,
      input  l_req_valid, l_req_write, l_addr, l_wdata,
      output l_req_ready, l_resp_valid, l_resp_data,
      output mem_address, mem_i_write, mem_i_data,
      input  mem_readData
   );

   modport master (
      output f_req_valid, f_addr,
      input  f_req_ready, f_resp_valid, f_resp_data,
      output l_req_valid, l_req_write, l_addr, l_wdata,
      input  l_req_ready, l_resp_valid, l_resp_data,
      input  mem_address, mem_i_write, mem_i_data,
      output mem_readData
   );
endinterface

// File: rtl/imem_arbiter.sv
// Single-cycle arbiter between instruction fetch and the program loader for one SRAM port,
// plus a BOOT/RUN sequencer that stalls the core until the image has been loaded.
module imem_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           boot_start,
   input  logic           boot_done,
   output logic           cpu_stall,
   imem_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [CNT_W-1:0]  starve_cnt_reg;
   logic [CNT_W-1:0]  starve_cnt_next;
   logic              resp_f_reg;
   logic              resp_l_reg;
   logic              grant_f;
   logic              grant_l;
   logic              starved;
   logic [ADDR_WIDTH-1:0] addr_sel;
   logic [DATA_WIDTH-1:0] rd_data;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= BOOT;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BOOT:    if (boot_done)  state_next = RUN;
         RUN:     if (boot_start) state_next = BOOT;
         default: state_next = BOOT;
      endcase
   end

   // Output logic: stall and the one-hot grant
   always_comb begin
      cpu_stall = (state_reg == BOOT);
      starved   = (starve_cnt_reg == STARVE_MAX);
      grant_f   = 1'b0;
      grant_l   = 1'b0;
      if (!reset) begin
         case (state_reg)
            BOOT: begin
               grant_l = bus.l_req_valid;
            end
            RUN: begin
               if (starved) begin
                  grant_l = bus.l_req_valid;
                  grant_f = bus.f_req_valid && !bus.l_req_valid;
               end else begin
                  grant_f = bus.f_req_valid;
                  grant_l = bus.l_req_valid && !bus.f_req_valid;
               end
            end
            default: begin
               grant_f = 1'b0;
               grant_l = 1'b0;
            end
         endcase
      end
   end

   // Counts consecutive cycles the loader waited behind fetch; frozen while booting
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (state_reg == RUN) begin
         if (grant_l || !bus.l_req_valid) begin
            starve_cnt_next = '0;
         end else if (grant_f && (starve_cnt_reg != STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt_reg <= '0;
         resp_f_reg     <= 1'b0;
         resp_l_reg     <= 1'b0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         resp_f_reg     <= grant_f;
         resp_l_reg     <= grant_l && !bus.l_req_write;
      end
   end

   always_comb begin
      addr_sel = '0;
      if (grant_f) begin
         addr_sel = bus.f_addr;
      end else if (grant_l) begin
         addr_sel = bus.l_addr;
      end
   end

   // SRAM read data is shared; the response valids say who it belongs to
   assign rd_data = bus.mem_readData;

   assign bus.f_req_ready  = grant_f;
   assign bus.l_req_ready  = grant_l;
   assign bus.mem_address  = addr_sel;
   assign bus.mem_i_write  = grant_l && bus.l_req_write;
   assign bus.mem_i_data   = bus.l_wdata;
   assign bus.f_resp_valid = resp_f_reg;
   assign bus.l_resp_valid = resp_l_reg;
   assign bus.f_resp_data  = rd_data;
   assign bus.l_resp_data  = rd_data;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: SRAM model, response scoreboard and one task per scenario.
module tb_imem_arbiter;

   logic clock;
   logic reset;
   logic boot_start;
   logic boot_done;
   logic cpu_stall;

   int checks = 0;
   int errors = 0;

   imem_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

   imem_arbiter #(
      .ADDR_WIDTH  (10),
      .DATA_WIDTH  (32),
      .STARVE_LIMIT(4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .boot_start(boot_start),
      .boot_done (boot_done),
      .cpu_stall (cpu_stall),
      .bus       (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-port SRAM, registered read, no read on write cycles
   logic [31:0] sram [0:1023];
   always @(posedge clock) begin
      if (bus.mem_i_write) sram[bus.mem_address] <= bus.mem_i_data;
      else                 bus.mem_readData <= sram[bus.mem_address];
   end

   // Scoreboard: expected read data pushed on grant, popped when the response valid shows up
   logic [31:0] shadow [0:1023];
   logic [31:0] exp_f_q [$];
   logic [31:0] exp_l_q [$];

   always @(negedge clock) begin
      logic [31:0] d;
      checks++;
      if (bus.f_resp_valid !== (exp_f_q.size() != 0)) begin
         errors++;
         $display("FAIL sb_f_valid: got %0b required %0b", bus.f_resp_valid, exp_f_q.size() != 0);
      end
      if (exp_f_q.size() != 0) begin
         d = exp_f_q.pop_front();
         checks++;
         if (bus.f_resp_data !== d) begin
            errors++;
            $display("FAIL sb_f_data: got %08h required %08h", bus.f_resp_data, d);
         end
      end
      checks++;
      if (bus.l_resp_valid !== (exp_l_q.size() != 0)) begin
         errors++;
         $display("FAIL sb_l_valid: got %0b required %0b", bus.l_resp_valid, exp_l_q.size() != 0);
      end
      if (exp_l_q.size() != 0) begin
         d = exp_l_q.pop_front();
         checks++;
         if (bus.l_resp_data !== d) begin
            errors++;
            $display("FAIL sb_l_data: got %08h required %08h", bus.l_resp_data, d);
         end
      end
      if (reset) begin
         exp_f_q.delete();
         exp_l_q.delete();
      end else begin
         if (bus.f_req_valid && bus.f_req_ready) begin
            exp_f_q.push_back(shadow[bus.f_addr]);
            $display("%0t fetch read  addr %0d", $time, bus.f_addr);
         end
         if (bus.l_req_valid && bus.l_req_ready) begin
            if (bus.l_req_write) begin
               shadow[bus.l_addr] = bus.l_wdata;
               $display("%0t load  write addr %0d data %08h", $time, bus.l_addr, bus.l_wdata);
            end else begin
               exp_l_q.push_back(shadow[bus.l_addr]);
               $display("%0t load  read  addr %0d", $time, bus.l_addr);
            end
         end
      end
   end

   function automatic logic [31:0] img(input int i);
      if (i == 0) return 32'h01100F13;
      if (i == 1) return 32'h00000E33;
      return 32'hC0DE0000 | 32'(i);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.f_req_valid = 1'b0;
      bus.f_addr      = '0;
      bus.l_req_valid = 1'b0;
      bus.l_req_write = 1'b0;
      bus.l_addr      = '0;
      bus.l_wdata     = '0;
      boot_start      = 1'b0;
      boot_done       = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.f_req_valid = 1'b1;
      bus.f_addr      = 10'd5;
      bus.l_req_valid = 1'b1;
      bus.l_req_write = 1'b1;
      bus.l_addr      = 10'd9;
      bus.l_wdata     = 32'h12345678;
      tick();
      @(negedge clock);
      checks++;
      if (bus.f_req_ready !== 1'b0 || bus.l_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got f=%0b l=%0b required 0 0", bus.f_req_ready, bus.l_req_ready);
      end
      checks++;
      if (bus.mem_i_write !== 1'b0 || bus.mem_address !== 10'd0) begin
         errors++;
         $display("FAIL reset_mem: got we=%0b addr=%0d required 0 0", bus.mem_i_write, bus.mem_address);
      end
      tick();
      reset = 1'b0;
      idle();
      @(negedge clock);
      checks++;
      if (cpu_stall !== 1'b1 || bus.f_resp_valid !== 1'b0 || bus.l_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got stall=%0b fv=%0b lv=%0b required 1 0 0",
                  cpu_stall, bus.f_resp_valid, bus.l_resp_valid);
      end
      tick();
   endtask

   task automatic test_boot_load();
      for (int i = 0; i < 13; i++) begin
         bus.f_req_valid = 1'b1;
         bus.f_addr      = 10'd0;
         bus.l_req_valid = 1'b1;
         bus.l_req_write = 1'b1;
         bus.l_addr      = 10'(i);
         bus.l_wdata     = img(i);
         boot_done       = (i == 12);
         @(negedge clock);
         checks++;
         if (bus.f_req_ready !== 1'b0 || bus.l_req_ready !== 1'b1 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL boot_grant[%0d]: got f=%0b l=%0b stall=%0b required 0 1 1",
                     i, bus.f_req_ready, bus.l_req_ready, cpu_stall);
         end
         tick();
      end
      idle();
      bus.f_req_valid = 1'b1;
      @(negedge clock);
      checks++;
      if (cpu_stall !== 1'b0 || bus.f_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL boot_first_fetch: got stall=%0b f=%0b required 0 1", cpu_stall, bus.f_req_ready);
      end
      tick();
      idle();
      @(negedge clock);
      checks++;
      if (bus.f_resp_valid !== 1'b1 || bus.f_resp_data !== 32'h01100F13) begin
         errors++;
         $display("FAIL boot_first_data: got v=%0b d=%08h required 1 01100f13",
                  bus.f_resp_valid, bus.f_resp_data);
      end
      tick();
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 14; i++) begin
         bus.f_req_valid = (i < 13);
         bus.f_addr      = 10'(i);
         @(negedge clock);
         if (i < 13) begin
            checks++;
            if (bus.f_req_ready !== 1'b1) begin
               errors++;
               $display("FAIL stream_ready[%0d]: got %0b required 1", i, bus.f_req_ready);
            end
         end
         if (i > 0) begin
            checks++;
            if (bus.f_resp_valid !== 1'b1 || bus.f_resp_data !== img(i - 1)) begin
               errors++;
               $display("FAIL stream_resp[%0d]: got v=%0b d=%08h required 1 %08h",
                        i - 1, bus.f_resp_valid, bus.f_resp_data, img(i - 1));
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_starvation(input string tag);
      byte got;
      byte exp;
      byte prev = "-";
      for (int k = 0; k < 11; k++) begin
         bus.f_req_valid = (k < 10);
         bus.f_addr      = 10'(k);
         bus.l_req_valid = (k < 10);
         bus.l_req_write = 1'b0;
         bus.l_addr      = 10'd5;
         @(negedge clock);
         if (k < 10) begin
            got = (bus.f_req_ready && bus.l_req_ready) ? "2" :
                  bus.f_req_ready ? "F" : bus.l_req_ready ? "L" : "-";
            exp = ((k % 5) == 4) ? "L" : "F";
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL %s_grant[%0d]: got %c required %c", tag, k, got, exp);
            end
         end else begin
            got = "-";
         end
         if (prev == "L") begin
            checks++;
            if (bus.l_resp_valid !== 1'b1 || bus.l_resp_data !== img(5)) begin
               errors++;
               $display("FAIL %s_lresp[%0d]: got v=%0b d=%08h required 1 %08h",
                        tag, k, bus.l_resp_valid, bus.l_resp_data, img(5));
            end
         end
         prev = got;
         tick();
      end
      idle();
   endtask

   task automatic test_write_then_read();
      bus.l_req_valid = 1'b1;
      bus.l_req_write = 1'b1;
      bus.l_addr      = 10'd7;
      bus.l_wdata     = 32'hDEADBEEF;
      @(negedge clock);
      checks++;
      if (bus.l_req_ready !== 1'b1 || bus.mem_i_write !== 1'b1 || bus.mem_address !== 10'd7) begin
         errors++;
         $display("FAIL wr_accept: got l=%0b we=%0b addr=%0d required 1 1 7",
                  bus.l_req_ready, bus.mem_i_write, bus.mem_address);
      end
      tick();
      bus.l_req_write = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.l_resp_valid !== 1'b0 || bus.l_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_no_resp: got lv=%0b l=%0b required 0 1", bus.l_resp_valid, bus.l_req_ready);
      end
      tick();
      idle();
      @(negedge clock);
      checks++;
      if (bus.l_resp_valid !== 1'b1 || bus.l_resp_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_after_wr: got v=%0b d=%08h required 1 deadbeef",
                  bus.l_resp_valid, bus.l_resp_data);
      end
      tick();
   endtask

   task automatic test_reboot();
      bus.f_req_valid = 1'b1;
      bus.f_addr      = 10'd3;
      boot_start      = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.f_req_ready !== 1'b1 || cpu_stall !== 1'b0) begin
         errors++;
         $display("FAIL reboot_grant: got f=%0b stall=%0b required 1 0", bus.f_req_ready, cpu_stall);
      end
      tick();
      boot_start = 1'b0;
      bus.f_addr = 10'd4;
      @(negedge clock);
      checks++;
      if (bus.f_resp_valid !== 1'b1 || bus.f_resp_data !== img(3) || cpu_stall !== 1'b1 ||
          bus.f_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reboot_inflight: got v=%0b d=%08h stall=%0b f=%0b required 1 %08h 1 0",
                  bus.f_resp_valid, bus.f_resp_data, cpu_stall, bus.f_req_ready, img(3));
      end
      tick();
      for (int c = 0; c < 4; c++) begin
         boot_done = (c == 3);
         @(negedge clock);
         checks++;
         if (bus.f_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reboot_hold[%0d]: got f=%0b required 0", c, bus.f_req_ready);
         end
         tick();
      end
      boot_done = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.f_req_ready !== 1'b1 || cpu_stall !== 1'b0) begin
         errors++;
         $display("FAIL reboot_resume: got f=%0b stall=%0b required 1 0", bus.f_req_ready, cpu_stall);
      end
      tick();
      idle();
      @(negedge clock);
      tick();
   endtask

   task automatic test_reset_mid_run();
      for (int k = 0; k < 3; k++) begin
         bus.f_req_valid = 1'b1;
         bus.f_addr      = 10'(k);
         bus.l_req_valid = 1'b1;
         bus.l_req_write = 1'b0;
         bus.l_addr      = 10'd5;
         @(negedge clock);
         checks++;
         if (bus.f_req_ready !== 1'b1 || bus.l_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_pre[%0d]: got f=%0b l=%0b required 1 0", k, bus.f_req_ready, bus.l_req_ready);
         end
         tick();
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.f_req_ready !== 1'b0 || bus.l_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset_ready: got f=%0b l=%0b required 0 0", bus.f_req_ready, bus.l_req_ready);
      end
      tick();
      reset = 1'b0;
      idle();
      boot_done = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.f_resp_valid !== 1'b0 || bus.l_resp_valid !== 1'b0 || cpu_stall !== 1'b1) begin
         errors++;
         $display("FAIL midrun_after_reset: got fv=%0b lv=%0b stall=%0b required 0 0 1",
                  bus.f_resp_valid, bus.l_resp_valid, cpu_stall);
      end
      tick();
      idle();
      test_starvation("restarve");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_boot_load();
      test_streaming();
      test_starvation("starve");
      test_write_then_read();
      test_reboot();
      test_reset_mid_run();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-cycle arbiter and boot sequencer for the single-port instruction SRAM (one access per cycle, 1-cycle registered read, no read on write cycles). It shares the SRAM between the core's instruction-fetch port (read-only) and the program loader/debug port (read/write). It also holds the core in a BOOT state until the loader signals that the program image has been written.

## Interface
- ADDR_WIDTH, 10, SRAM word-address width
- DATA_WIDTH, 32, SRAM word width
- STARVE_LIMIT, 4, consecutive loader-losing cycles in RUN before the loader is forced a grant (>=1)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- boot_start  in  1  pulse: RUN -> BOOT
- boot_done  in  1  pulse: BOOT -> RUN
- cpu_stall  out  1  high while in BOOT
- f_req_valid  in  1  fetch read request
- f_req_ready  out  1  fetch request granted this cycle
- f_addr  in  ADDR_WIDTH  fetch word address
- f_resp_valid  out  1  fetch read data valid
- f_resp_data  out  DATA_WIDTH  fetch read data
- l_req_valid  in  1  loader request
- l_req_ready  out  1  loader request granted this cycle
- l_req_write  in  1  1 = write, 0 = read
- l_addr  in  ADDR_WIDTH  loader word address
- l_wdata  in  DATA_WIDTH  loader write data
- l_resp_valid  out  1  loader read data valid
- l_resp_data  out  DATA_WIDTH  loader read data
- mem_address  out  ADDR_WIDTH  to SRAM address
- mem_i_write  out  1  to SRAM i_write
- mem_i_data  out  DATA_WIDTH  to SRAM i_data
- mem_readData  in  DATA_WIDTH  from SRAM readData

## Operation
- State machine: BOOT, RUN. Reset enters BOOT.
  - BOOT: boot_done=1 moves to RUN on the next edge.
  - RUN: boot_start=1 moves to BOOT on the next edge.
  - boot_start is ignored in BOOT. boot_done is ignored in RUN.
- cpu_stall = (state == BOOT), combinational.
- Grant rules, evaluated combinationally each cycle (at most one grant):
  - BOOT: the loader is granted whenever l_req_valid. Fetch is never granted.
  - RUN, starve_cnt < STARVE_LIMIT: fetch has priority. The loader is granted only if f_req_valid=0.
  - RUN, starve_cnt == STARVE_LIMIT: the loader has priority.
- f_req_ready = grant_f; l_req_ready = grant_l. A ready may depend on the same-cycle valid. A request transfers when valid && ready.
- SRAM drive:
  - mem_address: f_addr on grant_f, l_addr on grant_l, otherwise 0.
  - mem_i_write = grant_l && l_req_write.
  - mem_i_data = l_wdata.
- Starvation counter starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, on a RUN cycle with l_req_valid && grant_f.
  - Clears on grant_l or on any cycle with l_req_valid=0.
  - Holds in BOOT.
- Response tracking uses registers resp_f and resp_l:
  - resp_f <= grant_f.
  - resp_l <= grant_l && !l_req_write.
  - f_resp_valid = resp_f; l_resp_valid = resp_l.
  - f_resp_data = l_resp_data = mem_readData (pass-through). Data is meaningful only while the matching valid is high.
- Loader writes produce no response; acceptance (l_req_ready) is the completion.
- There is no response backpressure. Requesters must consume the data in the valid cycle.

## Timing
- Reset values:
  - state = BOOT, starve_cnt = 0, resp_f = resp_l = 0.
  - Hence cpu_stall=1, f_resp_valid=0, l_resp_valid=0.
  - During the reset cycle, f_req_ready = l_req_ready = mem_i_write = 0 and mem_address = 0 regardless of inputs.
- Read latency: the grant is in cycle N and the resp_valid plus data appear in cycle N+1.
- Back-to-back reads are accepted every cycle with full throughput.
- A write in cycle N is visible to a read granted in cycle N+1 (response in N+2).
- In-flight response across a state change: a fetch granted in the RUN cycle where boot_start=1 still returns f_resp_valid in the next cycle (BOOT).
- Reset mid-operation discards any pending response. resp valids are 0 in the cycle after reset.
- boot_done and l_req_valid in the same BOOT cycle: the loader is still granted that cycle. Fetch becomes eligible the following cycle.
- Both requesters held valid in RUN, STARVE_LIMIT=4: the grant pattern is F,F,F,F,L repeating. The loader waits at most STARVE_LIMIT cycles.
- Addresses are used as-is (no wrap logic). The SRAM wraps naturally at 2^ADDR_WIDTH.

## Test plan
- Boot load: after reset, drive loader writes of 0x01100F13 to addr 0 and 0x00000E33 to addr 1, with f_req_valid=1 throughout.
  - Required: f_req_ready stays 0 and cpu_stall=1.
  - After boot_done, a fetch of addr 0 returns f_resp_valid=1 with data 0x01100F13 one cycle after the grant.
- Streaming fetch: in RUN, fetch addr 0..12 on consecutive cycles.
  - Required: 13 consecutive f_resp_valid cycles with data matching the loaded words in order, no bubbles.
- Starvation: with STARVE_LIMIT=4, hold f_req_valid and l_req_valid (read addr 5) for 10 cycles.
  - Required: grants F,F,F,F,L,F,F,F,F,L.
  - l_resp_valid=1 in the cycle after each L grant, carrying word 5.
- Write-then-read: loader writes 0xDEADBEEF to addr 7 in cycle N and reads addr 7 in N+1.
  - Required: l_resp_valid in N+2 with data 0xDEADBEEF. No l_resp_valid in N+1.
- Reboot: assert boot_start in the same RUN cycle as a fetch grant.
  - Required: f_resp_valid=1 next cycle, cpu_stall=1 next cycle, no further fetch grants until boot_done.
- Reset mid-run: assert reset in a cycle with a pending read.
  - Required: both resp_valid=0 and cpu_stall=1 in the following cycle, starve_cnt cleared.
  - Verify the counter is cleared by re-running the starvation pattern, which must restart at F,F,F,F,L.
